// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the never-stalling pipeline result and buffered
// long-latency results onto the single regfile write port, with a pending-destination scoreboard.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  input  logic              lu_issue,
  input  logic [ADDR_W-1:0] lu_issue_addr,
  output logic              issue_busy,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int NREG  = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [NREG-1:0]   r_pending;

  logic              w_not_empty;
  logic              w_pipe_wr;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_nz;
  logic              w_push;
  logic              w_pop;

  assign w_not_empty = (r_count != '0);
  assign w_pipe_wr   = pipe_we && (pipe_waddr != '0);
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_nz   = (w_head_addr != '0);

  // Ready looks only at the registered count, so a full FIFO refuses even
  // when its head is leaving this same cycle.
  assign lu_ready = !rst && (r_count < FULL_CNT);
  assign w_push   = lu_valid && lu_ready;
  // A zero-address head needs no port, so it drains even behind a pipe write.
  assign w_pop    = !rst && w_not_empty && (!w_pipe_wr || !w_head_nz);

  assign chk_busy1  = !rst && (chk_addr1 != '0) && r_pending[chk_addr1];
  assign chk_busy2  = !rst && (chk_addr2 != '0) && r_pending[chk_addr2];
  assign issue_busy = !rst && (lu_issue_addr != '0) && r_pending[lu_issue_addr];

  // NOTE: every output gets a default before the if-chain so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (!rst) begin
      if (w_pipe_wr) begin
        we    = 1'b1;
        waddr = pipe_waddr;
        wdata = pipe_wdata;
      end else if (w_not_empty) begin
        we    = w_head_nz;
        waddr = w_head_addr;
        wdata = w_head_data;
      end
    end
  end

  // NOTE: the buffer storage is deliberately not reset; count and pointers
  // define which entries are live, so clearing the payload buys nothing.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= lu_waddr;
      r_fifo_data[r_wr_ptr] <= lu_wdata;
    end
  end

  // NOTE: state uses non-blocking assignments; for the pending bitmap the
  // later set statement overrides the earlier clear, so set wins on a collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop && w_head_nz) r_pending[w_head_addr] <= 1'b0;
      if (lu_issue && (lu_issue_addr != '0)) r_pending[lu_issue_addr] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_waddr;
  logic [DATA_W-1:0] pipe_wdata;
  logic              lu_issue;
  logic [ADDR_W-1:0] lu_issue_addr;
  logic              issue_busy;
  logic              lu_valid;
  logic              lu_ready;
  logic [ADDR_W-1:0] lu_waddr;
  logic [DATA_W-1:0] lu_wdata;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              chk_busy1;
  logic              chk_busy2;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr), .issue_busy(issue_busy),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered results as a queue, scoreboard as a bit array.
  ent_t q[$];
  bit   pend[1 << ADDR_W];

  always @(posedge clk) begin : model_update
    bit   pipe_wr;
    bit   can_take;
    ent_t h;
    ent_t e;
    if (rst) begin
      q.delete();
      for (int i = 0; i < (1 << ADDR_W); i++) pend[i] = 1'b0;
    end else begin
      pipe_wr  = pipe_we && (pipe_waddr != '0);
      can_take = (q.size() < DEPTH);
      if (q.size() > 0 && (!pipe_wr || q[0].addr == '0)) begin
        h = q.pop_front();
        if (h.addr != '0) pend[h.addr] = 1'b0;
      end
      if (lu_valid && can_take) begin
        e.addr = lu_waddr;
        e.data = lu_wdata;
        q.push_back(e);
      end
      if (lu_issue && lu_issue_addr != '0) pend[lu_issue_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin : model_compare
    logic              e_we;
    logic [ADDR_W-1:0] e_waddr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_ready;
    logic              e_b1, e_b2, e_bi;
    e_we = 1'b0; e_waddr = '0; e_wdata = '0;
    e_ready = !rst && (q.size() < DEPTH);
    e_b1 = !rst && chk_addr1 != '0 && pend[chk_addr1];
    e_b2 = !rst && chk_addr2 != '0 && pend[chk_addr2];
    e_bi = !rst && lu_issue_addr != '0 && pend[lu_issue_addr];
    if (!rst) begin
      if (pipe_we && pipe_waddr != '0) begin
        e_we = 1'b1; e_waddr = pipe_waddr; e_wdata = pipe_wdata;
      end else if (q.size() > 0) begin
        e_we = (q[0].addr != '0); e_waddr = q[0].addr; e_wdata = q[0].data;
      end
    end
    check("m_we", 64'(we), 64'(e_we));
    check("m_waddr", 64'(waddr), 64'(e_waddr));
    check("m_wdata", 64'(wdata), 64'(e_wdata));
    check("m_ready", 64'(lu_ready), 64'(e_ready));
    check("m_busy1", 64'(chk_busy1), 64'(e_b1));
    check("m_busy2", 64'(chk_busy2), 64'(e_b2));
    check("m_issue_busy", 64'(issue_busy), 64'(e_bi));
    check("push_full", 64'(!rst && lu_valid && lu_ready && q.size() >= DEPTH), 64'(0));
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we = 1'b0; lu_valid = 1'b0; lu_issue = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1111;
    lu_issue = 1'b0; lu_issue_addr = 5'd0; lu_valid = 1'b1; lu_waddr = 5'd1;
    lu_wdata = 32'h5; chk_addr1 = 5'd5; chk_addr2 = 5'd7;

    // Reset held two cycles with requests asserted
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_we", 64'(we), 64'(0));
      check("rst_ready", 64'(lu_ready), 64'(0));
      next();
    end
    rst = 1'b0; idle();
    @(negedge clk);
    check("post_rst_busy1", 64'(chk_busy1), 64'(0));
    check("post_rst_busy2", 64'(chk_busy2), 64'(0));
    check("post_rst_ready", 64'(lu_ready), 64'(1));
    next();

    // Issue addr 5, then deliver and drain its result
    lu_issue = 1'b1; lu_issue_addr = 5'd5; chk_addr1 = 5'd5;
    @(negedge clk);
    check("issue_busy1_same", 64'(chk_busy1), 64'(0));
    next();
    lu_issue = 1'b0; lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("issue_busy1_next", 64'(chk_busy1), 64'(1));
    check("accept_we", 64'(we), 64'(0));
    next();
    lu_valid = 1'b0;
    @(negedge clk);
    check("drain_we", 64'(we), 64'(1));
    check("drain_waddr", 64'(waddr), 64'(5));
    check("drain_wdata", 64'(wdata), 64'hDEADBEEF);
    check("drain_busy1", 64'(chk_busy1), 64'(1));
    next();
    @(negedge clk);
    check("after_drain_busy1", 64'(chk_busy1), 64'(0));
    check("after_drain_we", 64'(we), 64'(0));
    next();

    // Priority and backpressure: pipe busy 4 cycles, results to 7 and 8
    lu_issue = 1'b1; lu_issue_addr = 5'd7; next();
    lu_issue_addr = 5'd8; next();
    lu_issue = 1'b0; chk_addr1 = 5'd7; chk_addr2 = 5'd8;
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3000 + 32'(i);
      lu_valid = (i < 2); lu_waddr = 5'(7 + i); lu_wdata = 32'h70 + 32'(16 * i);
      @(negedge clk);
      check("prio_we", 64'(we), 64'(1));
      check("prio_waddr", 64'(waddr), 64'(3));
      check("prio_ready", 64'(lu_ready), 64'(i < 2));
      next();
    end
    idle();
    @(negedge clk);
    check("pop7_waddr", 64'(waddr), 64'(7));
    check("pop7_wdata", 64'(wdata), 64'h70);
    check("pop7_ready", 64'(lu_ready), 64'(0));
    next();
    @(negedge clk);
    check("pop8_waddr", 64'(waddr), 64'(8));
    check("pop8_wdata", 64'(wdata), 64'h80);
    check("pop8_ready", 64'(lu_ready), 64'(1));
    check("pop8_busy7", 64'(chk_busy1), 64'(0));
    next();
    @(negedge clk);
    check("empty_we", 64'(we), 64'(0));
    check("empty_busy8", 64'(chk_busy2), 64'(0));
    next();

    // Zero-address pipe write lets the FIFO drain
    pipe_we = 1'b1; pipe_waddr = 5'd4; pipe_wdata = 32'h44;
    lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'h99;
    next();
    pipe_waddr = 5'd0; lu_valid = 1'b0;
    @(negedge clk);
    check("zero_pipe_we", 64'(we), 64'(1));
    check("zero_pipe_waddr", 64'(waddr), 64'(9));
    check("zero_pipe_wdata", 64'(wdata), 64'h99);
    next();
    // Zero-address FIFO head pops silently behind a pipe write
    pipe_waddr = 5'd4; pipe_wdata = 32'h45;
    lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'hAA;
    next();
    lu_valid = 1'b0;
    @(negedge clk);
    check("zero_head_waddr", 64'(waddr), 64'(4));
    check("zero_head_wdata", 64'(wdata), 64'h45);
    next();
    idle();
    @(negedge clk);
    check("zero_head_gone_we", 64'(we), 64'(0));
    check("zero_head_gone_wdata", 64'(wdata), 64'(0));
    next();

    // Set/clear collision on addr 6
    lu_issue = 1'b1; lu_issue_addr = 5'd6; next();
    lu_issue = 1'b0; lu_valid = 1'b1; lu_waddr = 5'd6; lu_wdata = 32'h66; next();
    lu_valid = 1'b0; lu_issue = 1'b1; lu_issue_addr = 5'd6;
    @(negedge clk);
    check("coll_we", 64'(we), 64'(1));
    check("coll_waddr", 64'(waddr), 64'(6));
    next();
    lu_issue = 1'b0; chk_addr1 = 5'd6;
    @(negedge clk);
    check("coll_busy_kept", 64'(chk_busy1), 64'(1));
    next();

    // Reset mid-operation with two buffered entries
    lu_issue = 1'b1; lu_issue_addr = 5'd10; next();
    lu_issue_addr = 5'd11; next();
    lu_issue = 1'b0; pipe_we = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h3333;
    lu_valid = 1'b1; lu_waddr = 5'd10; lu_wdata = 32'hA0; next();
    lu_waddr = 5'd11; lu_wdata = 32'hB0; next();
    lu_valid = 1'b0; chk_addr1 = 5'd10; chk_addr2 = 5'd11;
    @(negedge clk);
    check("full_ready", 64'(lu_ready), 64'(0));
    check("full_busy10", 64'(chk_busy1), 64'(1));
    next();
    rst = 1'b1; pipe_we = 1'b0;
    @(negedge clk);
    check("mid_rst_we", 64'(we), 64'(0));
    check("mid_rst_busy1", 64'(chk_busy1), 64'(0));
    next();
    rst = 1'b0;
    @(negedge clk);
    check("rel_we", 64'(we), 64'(0));
    check("rel_ready", 64'(lu_ready), 64'(1));
    check("rel_busy10", 64'(chk_busy1), 64'(0));
    check("rel_busy11", 64'(chk_busy2), 64'(0));
    next();
    @(negedge clk);
    check("rel_we_next", 64'(we), 64'(0));
    next();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter for the register file's single write port. It merges two result sources onto that port. The first is the in-order pipeline result from MEM/WB, which can never stall. The second is results from a long-latency unit (divider / multi-cycle ops), delivered over a valid/ready handshake and held in a small FIFO. It also keeps a pending-destination scoreboard so decode can detect reads of registers whose long-latency result has not yet been written.

## Interface

Parameters:
- DATA_W, 32, register data width (`RegBus`)
- ADDR_W, 5, register address width (`RegAddrBus`)
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1'b1)
- pipe_we  in  1  pipeline write request this cycle
- pipe_waddr  in  ADDR_W  pipeline destination
- pipe_wdata  in  DATA_W  pipeline result
- lu_issue  in  1  long-latency op issued this cycle
- lu_issue_addr  in  ADDR_W  its destination register
- issue_busy  out  1  pending[lu_issue_addr]; issuer must not assert lu_issue while this is high
- lu_valid  in  1  long-latency result available
- lu_ready  out  1  arbiter can accept the result
- lu_waddr  in  ADDR_W  result destination
- lu_wdata  in  DATA_W  result data
- chk_addr1, chk_addr2  in  ADDR_W  decode read addresses
- chk_busy1, chk_busy2  out  1  register has a pending long-latency write
- we  out  1  regfile write enable
- waddr  out  ADDR_W  regfile write address
- wdata  out  DATA_W  regfile write data

## Operation

- **State:** FIFO_DEPTH-entry FIFO of {addr, data}; rd_ptr and wr_ptr; count (0..FIFO_DEPTH); pending bitmap, 2^ADDR_W bits.
- **Accept:** when lu_valid && lu_ready, push {lu_waddr, lu_wdata}. lu_ready = (count < FIFO_DEPTH) && !rst. It depends on registered count only, not on a same-cycle pop.
- **Write port priority (combinational):**
  - If pipe_we && pipe_waddr != 0: we=1, waddr/wdata from the pipe. The FIFO head stays.
  - Otherwise, if count > 0: we = (head.addr != 0), waddr/wdata = head, and the head pops at the clock edge.
  - Otherwise: we=0, waddr=0, wdata=0.
- **Zero-address entries:**
  - A pipe write to r0 counts as no write, so the FIFO may drain that cycle.
  - A FIFO head with addr 0 is popped without asserting we. This happens even when the pipe is writing, because no port is used.
- **Pending bitmap:**
  - Set bit lu_issue_addr on lu_issue when the address is nonzero.
  - Clear bit head.addr when a nonzero head is popped.
  - If set and clear hit the same address in one cycle, set wins.
  - Pipe writes never touch pending. Upstream prevents WAW hazards using chk_busy.
- **Busy outputs:**
  - chk_busyN = pending[chk_addrN], forced to 0 when chk_addrN == 0 or rst.
  - issue_busy is formed the same way.
- **Simultaneous push and pop:** count unchanged; both pointers advance and wrap modulo FIFO_DEPTH.
- **Push when full:** cannot happen because lu_ready=0. A bench assertion flags lu_valid && lu_ready && count==FIFO_DEPTH.

## Timing

- Pipeline results: zero-cycle latency. we/waddr/wdata follow pipe_* combinationally, and the regfile captures them at the same posedge.
- Long-latency results: a result accepted at edge N can be written in the cycle after N at the earliest, if the pipe is idle. It waits as long as pipe_we stays high with a nonzero address.
- Pending: set at the edge after lu_issue, so chk_busy is visible the next cycle. Cleared at the edge where the head writes, so chk_busy drops the following cycle. In the write cycle itself the regfile's write-through bypass supplies the data.
- **Reset** (rst high at posedge): count, pointers and pending all cleared; buffered entries are discarded.
- **Outputs while rst is high:** we=0, waddr=0, wdata=0, lu_ready=0, chk_busy1/2=0, issue_busy=0.
- **Reset mid-operation:** in-flight FIFO entries are lost and pending bits cleared. There is no write in the reset cycle.

## Test plan

- **Reset:** hold rst 2 cycles with lu_valid=1 and pipe_we=1 → we=0, lu_ready=0. After release: count=0, all chk_busy=0.
- **Issue and drain:**
  - lu_issue addr 5, then chk_addr1=5 → chk_busy1=1 from the next cycle.
  - lu_valid {5, 0xDEADBEEF} with the pipe idle → one cycle later we=1, waddr=5, wdata=0xDEADBEEF.
  - chk_busy1=0 the cycle after that.
- **Priority and backpressure:**
  - Keep pipe_we=1 (addr 3) for 4 cycles while pushing results to 7 and 8.
  - lu_ready drops after 2 accepts, and we tracks the pipe.
  - When the pipe goes idle, addr 7 is written and then addr 8, in order; lu_ready returns after the first pop.
- **Zero address:**
  - pipe_we=1 with waddr=0 and a FIFO entry at addr 9 → the addr 9 entry is written that cycle.
  - A FIFO entry with addr 0 is popped with we=0 while the pipe writes addr 4.
- **Set/clear collision:** in the cycle where the head for addr 6 writes, assert lu_issue addr 6 → pending[6] stays 1 afterwards.
- **Reset mid-operation:** with count=2, pulse rst for 1 cycle → no writes follow, lu_ready=1 after release, chk_busy=0 for both addresses.
